demux_tdm_6ch: RTL

Time-division 1-to-6 demultiplexer: takes a framed serial bit stream on one line and routes successive bits to channels 0..5, presenting the assembled 6-bit word in parallel. It is the receiving end of a serial link fed by the team's 6:1 multiplexer scanning its select input 0→5. It sits between that serial link and any parallel consumer.

---
 rtl/demux_pkg.sv | 19 +
 rtl/ch_decoder.sv | 26 ++
 rtl/demux_tdm_6ch.sv | 123 ++++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the TDM 1-to-N demultiplexer: state encoding,
// the default channel count and the parity helper.
package demux_pkg;

    localparam int DEMUX_NCH_DEF = 6;
    localparam int PAR_W         = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PARITY  = 2'd2
    } state_e;

    // Even-parity check: 1 means the covered bits hold an odd number of ones.
    function automatic logic parity_of(input logic [PAR_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ch_decoder.sv
// Channel index to one-hot write-enable decoder, gated by the enable input.
// It is the structural inverse of the scanning multiplexer on the far side of the link.
module ch_decoder
    import demux_pkg::*;
#(
    parameter int NCH   = DEMUX_NCH_DEF,
    parameter int SEL_W = 3
) (
    input  logic             en_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [NCH-1:0]   we_o
);

    // One enable per channel; every enable stays low while en_i is low.
    always_comb begin
        we_o = '0;
        for (int i = 0; i < NCH; i++) begin
            if (en_i && (sel_i == SEL_W'(i))) begin
                we_o[i] = 1'b1;
            end else begin
                we_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/demux_tdm_6ch.sv
// Time-division 1-to-NCH demultiplexer: assembles a framed serial stream into a parallel word.
// Optional feature macro: DEMUX_PARITY_EN (adds a trailing even-parity bit and parity_err).
module demux_tdm_6ch
    import demux_pkg::*;
#(
    parameter int NCH   = DEMUX_NCH_DEF,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [NCH-1:0]   word,
    output logic             word_valid,
    output logic [SEL_W-1:0] ch,
    output logic             busy,
    output logic             frame_err
`ifdef DEMUX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    state_e           state_q;
    logic [NCH-1:0]   shadow_q;
    logic [NCH-1:0]   shadow_d;
    logic [NCH-1:0]   word_q;
    logic             word_valid_q;
    logic [SEL_W-1:0] ch_q;
    logic             frame_err_q;
    logic             parity_err_q;
    logic             start_s;
    logic             wr_en_s;
    logic [SEL_W-1:0] wr_sel_s;
    logic [NCH-1:0]   we_s;

    assign start_s  = din_valid & sof;
    assign wr_en_s  = start_s | (din_valid & (state_q == S_COLLECT));
    assign wr_sel_s = start_s ? {SEL_W{1'b0}} : ch_q;

    ch_decoder #(.NCH(NCH), .SEL_W(SEL_W)) u_dec (
        .en_i  (wr_en_s),
        .sel_i (wr_sel_s),
        .we_o  (we_s)
    );

    // A new sof discards whatever the aborted frame had collected.
    always_comb begin
        if (start_s) begin
            shadow_d = ({NCH{din}} & we_s);
        end else begin
            shadow_d = (shadow_q & ~we_s) | ({NCH{din}} & we_s);
        end
    end

    // Frame FSM with channel counter, shadow register and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shadow_q     <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            ch_q         <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            shadow_q     <= shadow_d;
            if (start_s) begin
                frame_err_q <= (state_q != S_IDLE);
                ch_q        <= SEL_W'(1);
                state_q     <= S_COLLECT;
            end else if (din_valid) begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_IDLE;
                    end
                    S_COLLECT: begin
                        if (ch_q == SEL_W'(NCH - 1)) begin
                            ch_q <= '0;
`ifdef DEMUX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            word_q       <= shadow_d;
                            word_valid_q <= 1'b1;
                            state_q      <= S_IDLE;
`endif
                        end else begin
                            ch_q <= ch_q + SEL_W'(1);
                        end
                    end
`ifdef DEMUX_PARITY_EN
                    S_PARITY: begin
                        word_q       <= shadow_q;
                        word_valid_q <= 1'b1;
                        parity_err_q <= parity_of(PAR_W'({shadow_q, din}));
                        state_q      <= S_IDLE;
                    end
`endif
                    default: begin
                        state_q <= S_IDLE;
                        ch_q    <= '0;
                    end
                endcase
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign ch         = ch_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_err  = frame_err_q;
`ifdef DEMUX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
